// File: rtl/adc_conv_scheduler.sv
// adc_conv_scheduler: slot sequencer for AD7324 conversions through spi_ad7324.
// Picks the channel, runs START/WAIT/CAPTURE, checks chID, converts 2C to offset binary.
module adc_conv_scheduler #(
    parameter int M           = 12,
    parameter int VOUT_PRIO   = 1,
    parameter int FREE_RUN    = 0,
    parameter int GAP_CYC     = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        CLK20M,
    input  logic        rstHI,
    input  logic        EN,
    input  logic [3:0]  CH_MASK,
    input  logic        TRIG,
    output logic        SPI_START,
    output logic [1:0]  SPI_CH,
    input  logic [15:0] SPI_DATA,
    input  logic        SPI_DONE,
    output logic [M:0]  Vout,
    output logic [M:0]  Temp,
    output logic [M:0]  Vin,
    output logic [M:0]  Iout,
    output logic [3:0]  VALID,
    output logic        BUSY,
    output logic        TIMEOUT,
    output logic        TRIG_OVR,
    output logic [7:0]  ERR_CNT
);
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_WAIT, S_CAPT, S_GAP
    } state_t;

    localparam int CW = 16;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    ch_q, rr_q;
    logic          nv_q, pend_q, pend_d;
    logic [15:0]   data_q;
    logic [M:0]    res_q [4];
    logic [3:0]    valid_q;
    logic          ovr_q;
    logic [7:0]    err_q;

    logic       go, tmo, id_ok;
    logic [1:0] sel_ch, sel_rr;
    logic       sel_nv, hit;
    logic [2:0] cand;
    logic [M:0] conv;
    logic       unused_data;

    assign go    = EN && (CH_MASK != 4'd0)
                && (TRIG || pend_q || (FREE_RUN != 0));
    assign tmo   = (state_q == S_WAIT) && !SPI_DONE
                && (cnt_q == CW'(TIMEOUT_CYC - 1));
    assign id_ok = (data_q[14:13] == ch_q);
    // Flipping the sign bit adds 2^M: two's complement -> offset binary
    assign conv  = {~data_q[12], data_q[11:12-M]};
    assign unused_data = ^data_q;

    always_ff @(posedge CLK20M) begin
        if (rstHI) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (go) state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (SPI_DONE)  state_d = S_CAPT;
                else if (tmo)  state_d = S_GAP;
            end
            S_CAPT:  state_d = S_GAP;
            S_GAP:   if (cnt_q == CW'(GAP_CYC - 1)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        cnt_d = (state_d != state_q) ? '0 : cnt_q + CW'(1);
    end

    always_comb begin
        SPI_START = (state_q == S_START);
        BUSY      = (state_q != S_IDLE);
        TIMEOUT   = tmo;
    end

    always_comb begin
        pend_d = pend_q;
        if (state_q == S_IDLE) begin
            if (!EN || go) pend_d = 1'b0;
        end else if (TRIG && !pend_q) begin
            pend_d = 1'b1;
        end
    end

    // Channel pick for the next slot; only used on the IDLE->START edge
    always_comb begin
        sel_ch = 2'd0;
        sel_rr = rr_q;
        sel_nv = nv_q;
        hit    = 1'b0;
        cand   = 3'd0;
        if (VOUT_PRIO != 0) begin
            if (nv_q && CH_MASK[0]) begin
                sel_nv = 1'b0;
            end else begin
                sel_nv = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    cand = {1'b0, rr_q} + 3'(i);
                    if (cand > 3'd3) cand = cand - 3'd3;
                    if (!hit && CH_MASK[cand[1:0]]) begin
                        hit    = 1'b1;
                        sel_ch = cand[1:0];
                        sel_rr = (cand == 3'd3) ? 2'd1 : cand[1:0] + 2'd1;
                    end
                end
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                cand = {1'b0, rr_q + 2'(i)};
                if (!hit && CH_MASK[cand[1:0]]) begin
                    hit    = 1'b1;
                    sel_ch = cand[1:0];
                    sel_rr = cand[1:0] + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge CLK20M) begin
        if (rstHI) begin
            ch_q    <= 2'd0;
            rr_q    <= 2'd1;
            nv_q    <= 1'b1;
            pend_q  <= 1'b0;
            data_q  <= '0;
            res_q   <= '{default: '0};
            valid_q <= '0;
            ovr_q   <= 1'b0;
            err_q   <= '0;
        end else begin
            pend_q  <= pend_d;
            ovr_q   <= (state_q != S_IDLE) && TRIG && pend_q;
            valid_q <= '0;
            if (state_q == S_IDLE && go) begin
                ch_q <= sel_ch;
                rr_q <= sel_rr;
                nv_q <= sel_nv;
            end
            if (state_q == S_WAIT && SPI_DONE) data_q <= SPI_DATA;
            if (state_q == S_CAPT && id_ok) begin
                res_q[ch_q] <= conv;
                valid_q     <= 4'b0001 << ch_q;
            end
            if ((tmo || (state_q == S_CAPT && !id_ok)) && err_q != 8'hFF)
                err_q <= err_q + 8'd1;
        end
    end

    assign SPI_CH   = ch_q;
    assign Vout     = res_q[0];
    assign Temp     = res_q[1];
    assign Vin      = res_q[2];
    assign Iout     = res_q[3];
    assign VALID    = valid_q;
    assign TRIG_OVR = ovr_q;
    assign ERR_CNT  = err_q;

endmodule

// File: tb/tb_adc_conv_scheduler.sv
// tb_adc_conv_scheduler: directed bench for the AD7324 slot scheduler.
// Acts as the SPI block by hand; expected values are written out per step.
module tb_adc_conv_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [3:0]  mask = 4'hF;
    logic        trig = 1'b0;
    logic        spi_start;
    logic [1:0]  spi_ch;
    logic [15:0] spi_data = '0;
    logic        spi_done = 1'b0;
    logic [12:0] vout, temp, vin, iout;
    logic [3:0]  valid;
    logic        busy, tmo, trig_ovr;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;
    int starts = 0;
    int ovrs = 0;
    logic [7:0] err_m = '0;

    adc_conv_scheduler dut (
        .CLK20M(clk), .rstHI(rst), .EN(en), .CH_MASK(mask), .TRIG(trig),
        .SPI_START(spi_start), .SPI_CH(spi_ch), .SPI_DATA(spi_data),
        .SPI_DONE(spi_done), .Vout(vout), .Temp(temp), .Vin(vin),
        .Iout(iout), .VALID(valid), .BUSY(busy), .TIMEOUT(tmo),
        .TRIG_OVR(trig_ovr), .ERR_CNT(err_cnt)
    );

    always #25 clk = ~clk;

    always @(negedge clk) begin
        if (spi_start) starts++;
        if (trig_ovr) ovrs++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] res_of(input logic [1:0] ch);
        case (ch)
            2'd0: return vout;
            2'd1: return temp;
            2'd2: return vin;
            default: return iout;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_trig();
        trig = 1'b1;
        step();
        trig = 1'b0;
    endtask

    task automatic wait_start(input logic [1:0] exp_ch);
        int n = 0;
        while (!spi_start && n < 20) begin
            step();
            n++;
        end
        chk("start_seen", spi_start, 1);
        chk("spi_ch", spi_ch, exp_ch);
    endtask

    task automatic enter_wait();
        step();
        chk("start_one_cycle", spi_start, 0);
        chk("busy_in_wait", busy, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        chk("back_to_idle", busy, 0);
    endtask

    // Called in WAIT: return one transfer, then check the captured result
    task automatic respond(input logic [1:0] chid, input logic [12:0] pay,
                           input logic [1:0] exp_ch,
                           input logic [12:0] exp_res);
        spi_data = {1'b0, chid, pay};
        spi_done = 1'b1;
        step();
        spi_done = 1'b0;
        chk("valid_before_capture", valid, 0);
        step();
        if (chid == exp_ch) begin
            chk("valid_onehot", valid, 4'b0001 << exp_ch);
        end else begin
            err_m = err_m + 8'd1;
            chk("valid_on_mismatch", valid, 0);
        end
        chk("result", res_of(exp_ch), exp_res);
        chk("err_cnt", err_cnt, err_m);
    endtask

    task automatic slot(input logic [1:0] exp_ch, input logic [1:0] chid,
                        input logic [12:0] pay, input logic [12:0] exp_res);
        pulse_trig();
        wait_start(exp_ch);
        enter_wait();
        step();
        respond(chid, pay, exp_ch, exp_res);
        wait_idle();
    endtask

    logic [1:0]  seq_ch  [8] = '{2'd0, 2'd1, 2'd0, 2'd2,
                                 2'd0, 2'd3, 2'd0, 2'd1};
    logic [12:0] seq_pay [8] = '{13'h0FFF, 13'h0123, 13'h1000, 13'h1ABC,
                                 13'h0555, 13'h0800, 13'h1FFF, 13'h0AAA};
    logic [12:0] seq_res [8] = '{13'h1FFF, 13'h1123, 13'h0000, 13'h0ABC,
                                 13'h1555, 13'h1800, 13'h0FFF, 13'h1AAA};

    initial begin
        int n;
        int s0;
        int o0;

        repeat (3) step();
        chk("rst_start", spi_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ch", spi_ch, 0);
        chk("rst_vout", vout, 0);
        chk("rst_valid", valid, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_tmo", tmo, 0);
        rst = 1'b0;
        en = 1'b1;
        step();

        for (int i = 0; i < 8; i++)
            slot(seq_ch[i], seq_ch[i], seq_pay[i], seq_res[i]);
        chk("vout_final", vout, 13'h0FFF);
        chk("iout_final", iout, 13'h1800);

        // SPI_DONE withheld on a ch0 slot
        pulse_trig();
        wait_start(2'd0);
        n = 0;
        while (!tmo && n < 100) begin
            step();
            n++;
        end
        chk("timeout_delay", n, 64);
        step();
        err_m = 8'd1;
        chk("timeout_pulse_len", tmo, 0);
        chk("timeout_err", err_cnt, 1);
        chk("timeout_vout_kept", vout, 13'h0FFF);
        wait_idle();
        slot(2'd2, 2'd2, 13'h0001, 13'h1001);

        // chID mismatch on Temp
        mask = 4'b0010;
        slot(2'd1, 2'd2, 13'h0777, 13'h1AAA);
        mask = 4'hF;

        // Two extra TRIGs while busy: one pending, one dropped
        pulse_trig();
        wait_start(2'd0);
        o0 = ovrs;
        pulse_trig();
        step();
        pulse_trig();
        respond(2'd0, 13'h0002, 2'd0, 13'h1002);
        wait_idle();
        chk("ovr_count", ovrs - o0, 1);
        wait_start(2'd2);
        enter_wait();
        respond(2'd2, 13'h0003, 2'd2, 13'h1003);
        wait_idle();
        s0 = starts;
        repeat (10) step();
        chk("no_extra_slot", starts - s0, 0);

        // Reset while waiting on the SPI block
        pulse_trig();
        wait_start(2'd0);
        enter_wait();
        rst = 1'b1;
        step();
        chk("rstw_start", spi_start, 0);
        chk("rstw_busy", busy, 0);
        chk("rstw_ch", spi_ch, 0);
        chk("rstw_res", {vout, temp, vin, iout}, 0);
        chk("rstw_valid", valid, 0);
        chk("rstw_err", err_cnt, 0);
        chk("rstw_ovr", trig_ovr, 0);
        rst = 1'b0;
        err_m = '0;
        step();
        slot(2'd0, 2'd0, 13'h0100, 13'h1100);
        slot(2'd1, 2'd1, 13'h1F00, 13'h0F00);

        // Empty mask: TRIG ignored and not remembered
        mask = 4'b0000;
        s0 = starts;
        pulse_trig();
        repeat (5) step();
        chk("mask0_no_start", starts - s0, 0);
        chk("mask0_busy", busy, 0);
        mask = 4'hF;
        repeat (5) step();
        chk("mask0_no_pending", starts - s0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
